// File: rtl/arb_mux_pkg.sv
// Shared arbitration helpers: mode constants and a round-robin pick function
// sized for up to 16 requesters so other arbiters can reuse it.
package arb_mux_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;
  localparam int MAX_N     = 16;
  localparam int MAX_SEL_W = 4;

  typedef struct packed {
    logic                 any_valid;
    logic [MAX_SEL_W-1:0] idx;
  } pick_t;

  // Scans offsets from the highest down so the smallest offset from ptr wins;
  // a ptr of zero turns this into plain lowest-index priority.
  function automatic pick_t rr_pick(input logic [MAX_N-1:0]     valid,
                                    input logic [MAX_SEL_W-1:0] ptr,
                                    input int                   n);
    pick_t r;
    int    j;
    r = '0;
    for (int k = MAX_N - 1; k >= 0; k--) begin
      if (k < n) begin
        j = int'(ptr) + k;
        if (j >= n) j = j - n;
        if (valid[j[MAX_SEL_W-1:0]]) begin
          r.any_valid = 1'b1;
          r.idx       = j[MAX_SEL_W-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/arb_mux_grant.sv
// Combinational arbiter: picks one valid channel, either round-robin from ptr
// or fixed priority (lowest index) when mode is set.
module arb_mux_grant
  import arb_mux_pkg::*;
#(
  parameter  int N_IN  = 4,
  localparam int SEL_W = $clog2(N_IN)
) (
  input  logic [N_IN-1:0]  in_valid,
  input  logic [SEL_W-1:0] ptr,
  input  logic             mode,
  output logic [SEL_W-1:0] grant,
  output logic             any_valid
);

  pick_t pick;

  always_comb begin
    pick      = rr_pick(MAX_N'(in_valid), mode ? '0 : MAX_SEL_W'(ptr), N_IN);
    grant     = SEL_W'(pick.idx);
    any_valid = pick.any_valid;
  end

endmodule

// File: rtl/arb_mux_reg.sv
// N-input registered mux with an internal arbiter and valid/ready on all sides.
// Define ARB_MUX_REG_PERF_EN to add per-channel saturating grant counters.
module arb_mux_reg
  import arb_mux_pkg::*;
#(
  parameter  int N_IN     = 4,
  parameter  int WIDTH    = 32,
  parameter  int ARB_MODE = 0,
  localparam int SEL_W    = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IN-1:0]       in_valid,
  input  logic [N_IN*WIDTH-1:0] in_data,
  output logic [N_IN-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_sel,
`ifdef ARB_MUX_REG_PERF_EN
  input  logic                  out_ready,
  output logic [N_IN*16-1:0]    grant_cnt
`else
  input  logic                  out_ready
`endif
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] grant;
  logic             any_valid;
  logic             load_en;
  logic             xfer;
  logic [WIDTH-1:0] sel_data;

  arb_mux_grant #(.N_IN(N_IN)) u_grant (
    .in_valid  (in_valid),
    .ptr       (ptr),
    .mode      (ARB_MODE == ARB_FIXED),
    .grant     (grant),
    .any_valid (any_valid)
  );

  // in_ready follows out_ready combinationally through load_en only; the grant
  // itself never looks at out_ready.
  assign load_en  = !out_valid || out_ready;
  assign xfer     = load_en && any_valid;
  assign in_ready = xfer ? (N_IN'(1) << grant) : '0;
  assign sel_data = in_data[grant*WIDTH +: WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_sel   <= grant;
      if (ARB_MODE == ARB_RR)
        ptr <= (grant == SEL_W'(N_IN - 1)) ? '0 : grant + SEL_W'(1);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ARB_MUX_REG_PERF_EN
  logic [15:0] cnt [N_IN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_IN; i++) cnt[i] <= '0;
    end else if (xfer && cnt[grant] != 16'hFFFF) begin
      cnt[grant] <= cnt[grant] + 16'd1;
    end
  end

  for (genvar i = 0; i < N_IN; i++) begin : g_cnt
    assign grant_cnt[i*16 +: 16] = cnt[i];
  end
`endif

endmodule

// File: tb/tb_arb_mux_reg.sv
// Bench for arb_mux_reg: one round-robin and one fixed-priority instance share
// inputs and are checked against an arithmetic reference model.
module tb_arb_mux_reg;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic           out_ready;
  logic [N-1:0]   rdy_rr, rdy_fp;
  logic           ov_rr, ov_fp;
  logic [W-1:0]   od_rr, od_fp;
  logic [1:0]     os_rr, os_fp;
`ifdef ARB_MUX_REG_PERF_EN
  logic [N*16-1:0] cnt_rr, cnt_fp;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state, index 0 = round-robin instance, 1 = fixed priority.
  int           m_ptr   [2];
  bit           m_valid [2];
  logic [W-1:0] m_data  [2];
  int           m_sel   [2];
  int           m_cnt   [2][N];
  logic [N-1:0] exp_rdy [2];
  logic [N-1:0] obs_rdy [2];

  always #5 clk = ~clk;

  arb_mux_reg #(.N_IN(N), .WIDTH(W), .ARB_MODE(0)) dut_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_rr), .out_valid(ov_rr), .out_data(od_rr), .out_sel(os_rr),
`ifdef ARB_MUX_REG_PERF_EN
    .out_ready(out_ready), .grant_cnt(cnt_rr)
`else
    .out_ready(out_ready)
`endif
  );

  arb_mux_reg #(.N_IN(N), .WIDTH(W), .ARB_MODE(1)) dut_fp (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy_fp), .out_valid(ov_fp), .out_data(od_fp), .out_sel(os_fp),
`ifdef ARB_MUX_REG_PERF_EN
    .out_ready(out_ready), .grant_cnt(cnt_fp)
`else
    .out_ready(out_ready)
`endif
  );

  function automatic int pick(input int d, input logic [N-1:0] v);
    int start;
    start = (d == 0) ? m_ptr[d] : 0;
    for (int k = 0; k < N; k++) begin
      if (v[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N*W-1:0] rand_data();
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = $urandom;
    return r;
  endfunction

  function automatic logic [34:0] model_out(input int d);
    return {m_valid[d], 2'(m_sel[d]), m_data[d]};
  endfunction

  task automatic reset_model();
    for (int d = 0; d < 2; d++) begin
      m_ptr[d] = 0; m_valid[d] = 0; m_data[d] = '0; m_sel[d] = 0;
      for (int i = 0; i < N; i++) m_cnt[d][i] = 0;
    end
  endtask

  // One clock: drive at the falling edge, sample in_ready before the rising
  // edge, then advance the model and settle past the edge.
  task automatic applyStimulus(input logic [N-1:0] v, input logic [N*W-1:0] data, input bit ord);
    int g [2];
    bit ld [2];
    @(negedge clk);
    in_valid = v; in_data = data; out_ready = ord;
    #1;
    obs_rdy[0] = rdy_rr; obs_rdy[1] = rdy_fp;
    for (int d = 0; d < 2; d++) begin
      ld[d] = !m_valid[d] || ord;
      g[d]  = pick(d, v);
      exp_rdy[d] = (ld[d] && g[d] >= 0) ? (N'(1) << g[d]) : '0;
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (ld[d] && g[d] >= 0) begin
        m_valid[d] = 1; m_data[d] = data[g[d]*W +: W]; m_sel[d] = g[d];
        if (d == 0) m_ptr[d] = (g[d] + 1) % N;
        if (m_cnt[d][g[d]] < 65535) m_cnt[d][g[d]]++;
      end else if (m_valid[d] && ord) begin
        m_valid[d] = 0;
      end
    end
    #1;
  endtask

`ifdef ARB_MUX_REG_PERF_EN
  task automatic test_counters(input string tag);
    for (int i = 0; i < N; i++) begin
      n_cmp++;
      if (int'(cnt_rr[i*16 +: 16]) != m_cnt[0][i]) begin
        n_bad++;
        $display("[TB] FAIL %s cnt_rr[%0d]: got %0d want %0d", tag, i, cnt_rr[i*16 +: 16], m_cnt[0][i]);
      end
      n_cmp++;
      if (int'(cnt_fp[i*16 +: 16]) != m_cnt[1][i]) begin
        n_bad++;
        $display("[TB] FAIL %s cnt_fp[%0d]: got %0d want %0d", tag, i, cnt_fp[i*16 +: 16], m_cnt[1][i]);
      end
    end
  endtask
`endif

  task automatic test_reset();
    rst_n = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    for (int c = 0; c < 10; c++) begin
      applyStimulus('0, rand_data(), c[0]);
      n_cmp++;
      if ({ov_rr, os_rr, od_rr} !== 35'd0 || obs_rdy[0] !== '0) begin
        n_bad++;
        $display("[TB] FAIL reset_idle_rr c%0d: got v%b s%0d d%h r%b want all zero", c, ov_rr, os_rr, od_rr, obs_rdy[0]);
      end
      n_cmp++;
      if ({ov_fp, os_fp, od_fp} !== 35'd0 || obs_rdy[1] !== '0) begin
        n_bad++;
        $display("[TB] FAIL reset_idle_fp c%0d: got v%b s%0d d%h r%b want all zero", c, ov_fp, os_fp, od_fp, obs_rdy[1]);
      end
    end
`ifdef ARB_MUX_REG_PERF_EN
    test_counters("reset");
`endif
  endtask

  task automatic test_rr_fairness();
    logic [N*W-1:0] d;
    for (int i = 0; i < N; i++) d[i*W +: W] = W'(32'hA0 + i);
    for (int c = 0; c < 8; c++) begin
      applyStimulus('1, d, 1'b1);
      n_cmp++;
      if (ov_rr !== 1'b1 || os_rr !== 2'(c % N) || od_rr !== W'(32'hA0 + c % N)) begin
        n_bad++;
        $display("[TB] FAIL rr_fair c%0d: got v%b s%0d d%h want v1 s%0d d%h", c, ov_rr, os_rr, od_rr, c % N, 32'hA0 + c % N);
      end
      n_cmp++;
      if (obs_rdy[0] !== exp_rdy[0]) begin
        n_bad++;
        $display("[TB] FAIL rr_fair_ready c%0d: got %b want %b", c, obs_rdy[0], exp_rdy[0]);
      end
    end
`ifdef ARB_MUX_REG_PERF_EN
    test_counters("fairness");
`endif
  endtask

  task automatic test_fixed_priority();
    for (int c = 0; c < 6; c++) begin
      applyStimulus(4'b1010, rand_data(), 1'b1);
      n_cmp++;
      if (os_fp !== 2'd1 || ov_fp !== 1'b1 || od_fp !== m_data[1]) begin
        n_bad++;
        $display("[TB] FAIL fixed c%0d: got v%b s%0d d%h want v1 s1 d%h", c, ov_fp, os_fp, od_fp, m_data[1]);
      end
      n_cmp++;
      if (obs_rdy[1] !== 4'b0010) begin
        n_bad++;
        $display("[TB] FAIL fixed_ready c%0d: got %b want 0010", c, obs_rdy[1]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [N*W-1:0] d;
    int accepts;
    d = rand_data();
    d[2*W +: W] = 32'hDEADBEEF;
    applyStimulus('0, d, 1'b1);
    applyStimulus(4'b0100, d, 1'b0);
    accepts = 0;
    for (int c = 0; c < 5; c++) begin
      applyStimulus(4'b0100, d, 1'b0);
      n_cmp++;
      if (ov_rr !== 1'b1 || os_rr !== 2'd2 || od_rr !== 32'hDEADBEEF || obs_rdy[0] !== '0) begin
        n_bad++;
        $display("[TB] FAIL stall c%0d: got v%b s%0d d%h r%b want v1 s2 deadbeef r0000", c, ov_rr, os_rr, od_rr, obs_rdy[0]);
      end
    end
    applyStimulus('0, d, 1'b1);
    accepts++;
    for (int c = 0; c < 2; c++) begin
      if (ov_rr === 1'b1) accepts++;
      applyStimulus('0, d, 1'b1);
    end
    n_cmp++;
    if (accepts != 1) begin
      n_bad++;
      $display("[TB] FAIL consume_once: got %0d accepts want 1", accepts);
    end
  endtask

  task automatic test_wrap();
    applyStimulus(4'b0001, rand_data(), 1'b1);
    n_cmp++;
    if (obs_rdy[0] !== 4'b0001 || os_rr !== 2'd0 || ov_rr !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL wrap_grant0: got r%b s%0d v%b want r0001 s0 v1", obs_rdy[0], os_rr, ov_rr);
    end
    applyStimulus('1, rand_data(), 1'b1);
    n_cmp++;
    if (os_rr !== 2'd1 || od_rr !== m_data[0]) begin
      n_bad++;
      $display("[TB] FAIL wrap_next: got s%0d d%h want s1 d%h", os_rr, od_rr, m_data[0]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      applyStimulus(N'($urandom), rand_data(), $urandom_range(0, 3) != 0);
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (obs_rdy[d] !== exp_rdy[d]) begin
          n_bad++;
          $display("[TB] FAIL rand_ready%0d c%0d: got %b want %b", d, c, obs_rdy[d], exp_rdy[d]);
        end
      end
      n_cmp++;
      if ({ov_rr, os_rr, od_rr} !== model_out(0)) begin
        n_bad++;
        $display("[TB] FAIL rand_out_rr c%0d: got %h want %h", c, {ov_rr, os_rr, od_rr}, model_out(0));
      end
      n_cmp++;
      if ({ov_fp, os_fp, od_fp} !== model_out(1)) begin
        n_bad++;
        $display("[TB] FAIL rand_out_fp c%0d: got %h want %h", c, {ov_fp, os_fp, od_fp}, model_out(1));
      end
    end
  endtask

  task automatic test_async_reset();
    applyStimulus('1, rand_data(), 1'b1);
    applyStimulus('1, rand_data(), 1'b0);
    applyStimulus('1, rand_data(), 1'b0);
    n_cmp++;
    if (ov_rr !== 1'b1 || ov_fp !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL pre_reset_stall: got rr%b fp%b want 1 1", ov_rr, ov_fp);
    end
    #2;
    rst_n = 1'b0;
    #1;
    reset_model();
    n_cmp++;
    if ({ov_rr, os_rr, od_rr, ov_fp, os_fp, od_fp} !== 70'd0) begin
      n_bad++;
      $display("[TB] FAIL async_clear: got rr v%b s%0d d%h fp v%b s%0d d%h want zero", ov_rr, os_rr, od_rr, ov_fp, os_fp, od_fp);
    end
`ifdef ARB_MUX_REG_PERF_EN
    test_counters("async_reset");
`endif
    @(negedge clk);
    in_valid = '0;
    rst_n = 1'b1;
    applyStimulus(4'b1100, rand_data(), 1'b1);
    n_cmp++;
    if (os_rr !== 2'd2 || ov_rr !== 1'b1 || od_rr !== m_data[0]) begin
      n_bad++;
      $display("[TB] FAIL post_reset_grant: got s%0d v%b d%h want s2 v1 d%h", os_rr, ov_rr, od_rr, m_data[0]);
    end
  endtask

  initial begin
    test_reset();
    test_rr_fairness();
    test_fixed_priority();
    test_backpressure();
    test_wrap();
    test_random();
`ifdef ARB_MUX_REG_PERF_EN
    test_counters("random");
`endif
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
